// File: rtl/xnor_popcount_acc_if.sv
// Signal bundle between the binary-neuron accumulator, its beat counter and the result consumer.
// slave is the accumulator's view; master is the view of whatever drives it.
interface xnor_popcount_acc_if #(
  parameter int unsigned CHUNK_W = 8,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned ACC_W   = 11
);
  logic               start;
  logic [ACC_W-1:0]   threshold;
  logic               cnt_en;
  logic               cnt_fin;
  logic [CNT_W-1:0]   cnt_idx;
  logic [CHUNK_W-1:0] act_bits;
  logic [CHUNK_W-1:0] wgt_bits;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic [ACC_W-1:0]   out_sum;
  logic               seq_err;

  modport slave (
    input  start, threshold, cnt_fin, cnt_idx, act_bits, wgt_bits, out_ready,
    output cnt_en, busy, out_valid, out_bit, out_sum, seq_err
  );

  modport master (
    output start, threshold, cnt_fin, cnt_idx, act_bits, wgt_bits, out_ready,
    input  cnt_en, busy, out_valid, out_bit, out_sum, seq_err
  );
endinterface

// File: rtl/xnor_popcount_acc.sv
// Binary-neuron accumulator: XNOR-popcounts one chunk per counter beat, then thresholds the
// saturated sum into one activation bit presented on a valid/ready output.
module xnor_popcount_acc #(
  parameter int unsigned CHUNK_W = 8,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned ACC_W   = 11
) (
  input logic                clk,
  input logic                rst,
  xnor_popcount_acc_if.slave bus
);
  localparam int unsigned PopW = $clog2(CHUNK_W + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   thr_q, thr_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   exp_idx_q, exp_idx_d;
  logic               out_valid_q, out_valid_d;
  logic               out_bit_q, out_bit_d;
  logic               seq_err_q, seq_err_d;

  logic [CHUNK_W-1:0] match;
  logic [PopW-1:0]    pop;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   acc_sat;

  assign match = ~(bus.act_bits ^ bus.wgt_bits);

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      pop = pop + PopW'(match[i]);
    end
  end

  // One spare bit catches the carry so the sum can clamp instead of wrapping.
  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(pop);
  assign acc_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    thr_d       = thr_q;
    out_sum_d   = out_sum_q;
    exp_idx_d   = exp_idx_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    seq_err_d   = seq_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          thr_d     = bus.threshold;
          acc_d     = '0;
          exp_idx_d = '0;
          seq_err_d = 1'b0;
          state_d   = StAcc;
        end
      end
      StAcc: begin
        if (bus.cnt_fin) begin
          out_sum_d   = acc_q;
          out_bit_d   = (acc_q >= thr_q);
          out_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          acc_d     = acc_sat;
          exp_idx_d = exp_idx_q + CNT_W'(1);
          if (bus.cnt_idx != exp_idx_q) begin
            seq_err_d = 1'b1;
          end
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      thr_q       <= '0;
      out_sum_q   <= '0;
      exp_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      out_sum_q   <= out_sum_d;
      exp_idx_q   <= exp_idx_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign bus.cnt_en    = (state_q == StAcc);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Scoreboard bench for xnor_popcount_acc: a beat-counter model feeds chunks, expected results are
// queued at start and checked by a monitor whenever out_valid rises.
module tb_xnor_popcount_acc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xnor_popcount_acc_if bus ();
  xnor_popcount_acc dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string nm;
    int    b;
    int    sum;
    int    err;
    int    lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic ov_prev = 1'b0;

  // Beat-counter model: indices 0..nbeats-1 with fin low, then fin high until cleared.
  int         nbeats = 0;
  int         pos = 0;
  bit         skip = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [7:0] act_v = '0;
  logic [7:0] wgt_v = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_clr) pos <= 0;
    else if (bus.cnt_en) pos <= pos + 1;
  end

  assign bus.cnt_fin  = (pos >= nbeats);
  assign bus.cnt_idx  = 7'(pos + ((skip && pos >= 2) ? 1 : 0));
  assign bus.act_bits = act_v;
  assign bus.wgt_bits = wgt_v;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid && !ov_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({e.nm, "_out_sum"}, int'(bus.out_sum), e.sum);
        chk({e.nm, "_out_bit"}, int'(bus.out_bit), e.b);
        chk({e.nm, "_seq_err"}, int'(bus.seq_err), e.err);
        chk({e.nm, "_latency"}, cyc - start_cyc, e.lat);
      end
    end
    ov_prev <= bus.out_valid;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic issue_start(input logic [10:0] thr);
    bus.threshold = thr;
    bus.start     = 1'b1;
    start_cyc     = cyc;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, int'(bus.busy), 0);
  endtask

  task automatic clear_counter();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic run_pass(input string nm, input int nb, input logic [7:0] a, input logic [7:0] w,
                          input logic [10:0] thr, input bit sk, input bit clr,
                          input int eb, input int es, input int ee);
    nbeats = nb;
    act_v  = a;
    wgt_v  = w;
    skip   = sk;
    if (clr) clear_counter();
    exp_q.push_back('{nm, eb, es, ee, clr ? nb + 2 : 2});
    issue_start(thr);
    chk({nm, "_seq_err_cleared"}, int'(bus.seq_err), 0);
    wait_done(nm);
  endtask

  initial begin
    int n;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.threshold = '0;
    bus.out_ready = 1'b1;
    tick(3);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cnt_en", int'(bus.cnt_en), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_bit", int'(bus.out_bit), 0);
    chk("rst_seq_err", int'(bus.seq_err), 0);
    rst = 1'b1;
    tick(2);

    run_pass("all_ones", 4, 8'hFF, 8'hFF, 11'd32, 1'b0, 1'b1, 1, 32, 0);
    run_pass("no_match", 1, 8'hF0, 8'h0F, 11'd1, 1'b0, 1'b1, 0, 0, 0);
    run_pass("full_match", 1, 8'hA5, 8'hA5, 11'd1, 1'b0, 1'b1, 1, 8, 0);
    // Counter left at fin: zero beats.
    run_pass("fin_first", 1, 8'hA5, 8'hA5, 11'd5, 1'b0, 1'b0, 0, 0, 0);

    // Back-pressure with ignored starts.
    nbeats = 4; act_v = 8'hFF; wgt_v = 8'hFF; skip = 1'b0;
    clear_counter();
    bus.out_ready = 1'b0;
    exp_q.push_back('{"stall", 1, 32, 0, 6});
    issue_start(11'd32);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick(1);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 1);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_out_sum", int'(bus.out_sum), 32);
      chk("stall_out_bit", int'(bus.out_bit), 1);
      tick(1);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick(1);
    chk("hs_busy", int'(bus.busy), 0);
    chk("hs_out_valid", int'(bus.out_valid), 0);
    chk("hs_out_sum_kept", int'(bus.out_sum), 32);
    tick(3);
    chk("no_queued_start", int'(bus.busy), 0);

    run_pass("skip_idx", 4, 8'hFF, 8'hFF, 11'd33, 1'b1, 1'b1, 0, 32, 1);
    chk("seq_err_held", int'(bus.seq_err), 1);
    run_pass("long_thr1025", 128, 8'h00, 8'h00, 11'd1025, 1'b0, 1'b1, 0, 1024, 0);
    run_pass("long_thr1024", 128, 8'h00, 8'h00, 11'd1024, 1'b0, 1'b1, 1, 1024, 0);

    // Abort mid-accumulation.
    nbeats = 20; act_v = 8'hFF; wgt_v = 8'h00; skip = 1'b0;
    clear_counter();
    issue_start(11'd0);
    n = 0;
    while (pos < 10 && n < 50) begin
      tick(1);
      n++;
    end
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_cnt_en", int'(bus.cnt_en), 0);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_out_sum", int'(bus.out_sum), 0);
    chk("abort_out_bit", int'(bus.out_bit), 0);
    tick(1);
    rst = 1'b1;
    tick(30);
    chk("abort_stays_idle", int'(bus.busy), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
